aq_ifu_bht_pred_array: RTL and testbench

Parametrised branch-history-table storage controller for the IFU. It wraps a single-port SRAM with a post-reset/invalidate initialisation sweep, a one-entry posted write buffer that gives reads priority over writes, and a registered read port. It sits between the IFU BHT prediction/update logic and the SRAM macro, and replaces the fixed 1024x16 array wrapper.

---
 rtl/aq_ifu_bht_pkg.sv | 16 +
 rtl/aq_spsram_param.sv | 29 ++
 rtl/gated_clk_cell.sv | 26 ++
 rtl/aq_ifu_bht_pred_array.sv | 200 ++++++++++++++++++++
 tb/tb_aq_ifu_bht_pred_array.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/aq_ifu_bht_pkg.sv
// Shared constants for the IFU branch-history-table storage controller:
// FSM state encoding, default geometry and the init-sweep fill pattern.
package aq_ifu_bht_pkg;

   typedef logic [0:0] bht_state_t;

   localparam bht_state_t BHT_IDLE = 1'b0;
   localparam bht_state_t BHT_INIT = 1'b1;

   localparam int BHT_IDX_W  = 10;
   localparam int BHT_DATA_W = 16;

   // Every 2-bit counter starts weakly-not-taken.
   localparam logic [1:0] BHT_INIT_PAT = 2'b01;

endpackage

// File: rtl/aq_spsram_param.sv
// Behavioural single-port SRAM, 2^ADDR_W x DATA_W, active-low CEN/GWEN/WEN,
// one-cycle registered read; Q holds between reads.
module aq_spsram_param #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic [ADDR_W-1:0] A,
   input  logic              CEN,
   input  logic              CLK,
   input  logic [DATA_W-1:0] D,
   input  logic              GWEN,
   input  logic [DATA_W-1:0] WEN,
   output logic [DATA_W-1:0] Q
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // WEN bits low select which data bits are written; a write leaves Q untouched.
   always_ff @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) begin
            mem[A] <= (mem[A] & WEN) | (D & ~WEN);
         end else begin
            Q <= mem[A];
         end
      end
   end

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate shared across the IFU; scan enable forces
// the clock on so test patterns always reach gated flops.
module gated_clk_cell (
   input  logic clk_in,
   input  logic global_en,
   input  logic module_en,
   input  logic local_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);

   logic clk_en_bf_latch;
   logic clk_en_af_latch;

   assign clk_en_bf_latch = (global_en & (module_en | local_en)) | pad_yy_icg_scan_en;

   // Enable is captured while the clock is low so the gated clock never glitches.
   always_latch begin
      if (!clk_in) begin
         clk_en_af_latch <= clk_en_bf_latch;
      end
   end

   assign clk_out = clk_in & clk_en_af_latch;

endmodule

// File: rtl/aq_ifu_bht_pred_array.sv
// BHT storage controller: init sweep, one-entry posted write buffer and read port
// around a single-port SRAM. Optional read bypass of the buffer: AQ_BHT_WBUF_BYPASS_EN.
module aq_ifu_bht_pred_array
   import aq_ifu_bht_pkg::*;
#(
   parameter int              IDX_W    = BHT_IDX_W,
   parameter int              DATA_W   = BHT_DATA_W,
   parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W/2{BHT_INIT_PAT}}
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst,
   input  logic              cp0_yy_clk_en,
   input  logic              cp0_ifu_icg_en,
   input  logic              pad_yy_icg_scan_en,
   input  logic              bht_inv_req,
   input  logic              bht_rd_vld,
   input  logic [IDX_W-1:0]  bht_rd_idx,
   output logic [DATA_W-1:0] bht_rd_data,
   output logic              bht_rd_data_vld,
   input  logic              bht_wr_vld,
   output logic              bht_wr_rdy,
   input  logic [IDX_W-1:0]  bht_wr_idx,
   input  logic [DATA_W-1:0] bht_wr_data,
   input  logic [DATA_W-1:0] bht_wr_mask,
   output logic              bht_busy
);

   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   bht_state_t        state;
   logic [IDX_W-1:0]  init_cnt;
   logic              busy;
   logic              inv_go;
   logic              rd_acc;
   logic              wr_acc;
   logic              drain;

   logic              buf_vld;
   logic [IDX_W-1:0]  buf_idx;
   logic [DATA_W-1:0] buf_data;
   logic [DATA_W-1:0] buf_mask;

   logic              sram_clk;
   logic              icg_local_en;
   logic              sram_cen;
   logic              sram_gwen;
   logic [IDX_W-1:0]  sram_a;
   logic [DATA_W-1:0] sram_d;
   logic [DATA_W-1:0] sram_wen;
   logic [DATA_W-1:0] sram_q;

   logic              rd_pend;
   logic [DATA_W-1:0] rd_hold;
   logic [DATA_W-1:0] rd_merged;

   assign busy       = (state == BHT_INIT);
   assign inv_go     = bht_inv_req & ~busy;
   assign rd_acc     = bht_rd_vld & ~busy;
   assign bht_wr_rdy = ~busy & ~buf_vld;
   assign wr_acc     = bht_wr_vld & bht_wr_rdy;
   assign drain      = ~busy & buf_vld & ~bht_rd_vld;
   assign bht_busy   = busy;

   // The sweep runs to completion; an invalidate only takes effect from IDLE.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state    <= BHT_INIT;
         init_cnt <= '0;
      end else begin
         case (state)
            BHT_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == IDX_LAST) begin
                  state <= BHT_IDLE;
               end
            end
            default: begin
               if (bht_inv_req) begin
                  state    <= BHT_INIT;
                  init_cnt <= '0;
               end
            end
         endcase
      end
   end

   // A write colliding with a read is parked here; reads always win the port.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         buf_vld  <= 1'b0;
         buf_idx  <= '0;
         buf_data <= '0;
         buf_mask <= '0;
      end else if (inv_go) begin
         buf_vld <= 1'b0;
      end else if (wr_acc && rd_acc) begin
         buf_vld  <= 1'b1;
         buf_idx  <= bht_wr_idx;
         buf_data <= bht_wr_data;
         buf_mask <= bht_wr_mask;
      end else if (drain) begin
         buf_vld <= 1'b0;
      end
   end

   // Port arbitration: init write, read, buffer drain, direct write.
   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_a    = '0;
      sram_d    = '0;
      sram_wen  = '1;
      if (busy) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_a    = init_cnt;
         sram_d    = INIT_VAL;
         sram_wen  = '0;
      end else if (bht_rd_vld) begin
         sram_cen  = 1'b0;
         sram_a    = bht_rd_idx;
      end else if (buf_vld) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_a    = buf_idx;
         sram_d    = buf_data;
         sram_wen  = ~buf_mask;
      end else if (bht_wr_vld) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_a    = bht_wr_idx;
         sram_d    = bht_wr_data;
         sram_wen  = ~bht_wr_mask;
      end
   end

   assign icg_local_en = busy | bht_rd_vld | bht_wr_vld | buf_vld | bht_inv_req;

   gated_clk_cell x_bht_sram_icg (
      .clk_in             (forever_cpuclk),
      .global_en          (cp0_yy_clk_en),
      .module_en          (cp0_ifu_icg_en),
      .local_en           (icg_local_en),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (sram_clk)
   );

   aq_spsram_param #(
      .ADDR_W (IDX_W),
      .DATA_W (DATA_W)
   ) x_bht_sram (
      .A    (sram_a),
      .CEN  (sram_cen),
      .CLK  (sram_clk),
      .D    (sram_d),
      .GWEN (sram_gwen),
      .WEN  (sram_wen),
      .Q    (sram_q)
   );

`ifdef AQ_BHT_WBUF_BYPASS_EN
   logic              byp_hit;
   logic [DATA_W-1:0] byp_data;
   logic [DATA_W-1:0] byp_mask;

   // Buffer contents are snapshotted in the read cycle and merged over Q next cycle.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         byp_hit  <= 1'b0;
         byp_data <= '0;
         byp_mask <= '0;
      end else if (rd_acc) begin
         byp_hit  <= buf_vld & (buf_idx == bht_rd_idx);
         byp_data <= buf_data;
         byp_mask <= buf_mask;
      end
   end

   assign rd_merged = byp_hit ? ((sram_q & ~byp_mask) | (byp_data & byp_mask)) : sram_q;
`else
   assign rd_merged = sram_q;
`endif

   // The SRAM Q register supplies fresh data; rd_hold keeps it for later cycles.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         rd_pend <= 1'b0;
         rd_hold <= '0;
      end else begin
         rd_pend <= rd_acc;
         if (rd_pend) begin
            rd_hold <= rd_merged;
         end
      end
   end

   assign bht_rd_data     = rd_pend ? rd_merged : rd_hold;
   assign bht_rd_data_vld = rd_pend;

endmodule

// File: tb/tb_aq_ifu_bht_pred_array.sv
// Self-checking bench for aq_ifu_bht_pred_array at IDX_W=4 against a
// table-level model (entry array, pending-write slot, busy countdown).
module tb_aq_ifu_bht_pred_array;

   localparam int IW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << IW;
   localparam logic [DW-1:0] FILL = 16'h5555;

   logic          clk;
   logic          rst;
   logic          inv_req;
   logic          rd_vld;
   logic [IW-1:0] rd_idx;
   logic [DW-1:0] rd_data;
   logic          rd_data_vld;
   logic          wr_vld;
   logic          wr_rdy;
   logic [IW-1:0] wr_idx;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] wr_mask;
   logic          busy;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DW-1:0] m_mem [DEPTH];
   int            m_busy_left;
   logic          m_bvld;
   logic [IW-1:0] m_bidx;
   logic [DW-1:0] m_bdata;
   logic [DW-1:0] m_bmask;
   logic [DW-1:0] m_rd_data;
   logic          m_rd_vld;

   aq_ifu_bht_pred_array #(
      .IDX_W  (IW),
      .DATA_W (DW)
   ) dut (
      .forever_cpuclk     (clk),
      .cpurst             (rst),
      .cp0_yy_clk_en      (1'b1),
      .cp0_ifu_icg_en     (1'b0),
      .pad_yy_icg_scan_en (1'b0),
      .bht_inv_req        (inv_req),
      .bht_rd_vld         (rd_vld),
      .bht_rd_idx         (rd_idx),
      .bht_rd_data        (rd_data),
      .bht_rd_data_vld    (rd_data_vld),
      .bht_wr_vld         (wr_vld),
      .bht_wr_rdy         (wr_rdy),
      .bht_wr_idx         (wr_idx),
      .bht_wr_data        (wr_data),
      .bht_wr_mask        (wr_mask),
      .bht_busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, d, m);
      return (old & ~m) | (d & m);
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
         $error("[TB] check %s failed", tag);
      end
   endtask

   task automatic modelFill();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
      m_busy_left = DEPTH;
      m_bvld      = 1'b0;
   endtask

   // Called at posedge+1; reset is applied immediately and released one edge later.
   task automatic doReset();
      rst = 1'b1;
      inv_req = 0; rd_vld = 0; wr_vld = 0;
      #2;
      checkOutput("rst_rd_data", rd_data, '0);
      checkOutput("rst_rd_vld", {15'd0, rd_data_vld}, '0);
      checkOutput("rst_busy", {15'd0, busy}, 16'd1);
      checkOutput("rst_wr_rdy", {15'd0, wr_rdy}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      modelFill();
      m_rd_data = '0;
      m_rd_vld  = 1'b0;
   endtask

   // One clock cycle: drive inputs, check the cycle's outputs, advance the model.
   task automatic applyStimulus(input logic inv, input logic rv, input logic [IW-1:0] ridx,
                                input logic wv, input logic [IW-1:0] widx,
                                input logic [DW-1:0] wd, input logic [DW-1:0] wm);
      logic          m_busy;
      logic          m_rdy;
      logic [DW-1:0] val;
      inv_req = inv; rd_vld = rv; rd_idx = ridx;
      wr_vld = wv; wr_idx = widx; wr_data = wd; wr_mask = wm;
      #1;
      m_busy = (m_busy_left > 0);
      m_rdy  = !m_busy && !m_bvld;
      checkOutput("busy", {15'd0, busy}, {15'd0, m_busy});
      checkOutput("wr_rdy", {15'd0, wr_rdy}, {15'd0, m_rdy});
      checkOutput("rd_data_vld", {15'd0, rd_data_vld}, {15'd0, m_rd_vld});
      checkOutput("rd_data", rd_data, m_rd_data);
      if (m_busy) begin
         m_busy_left--;
         m_rd_vld = 1'b0;
      end else begin
         m_rd_vld = rv;
         if (rv) begin
            val = m_mem[ridx];
`ifdef AQ_BHT_WBUF_BYPASS_EN
            if (m_bvld && m_bidx == ridx) val = merge(val, m_bdata, m_bmask);
`endif
            m_rd_data = val;
         end
         if (!rv && m_bvld) begin
            m_mem[m_bidx] = merge(m_mem[m_bidx], m_bdata, m_bmask);
            m_bvld = 1'b0;
         end else if (wv && m_rdy) begin
            if (rv) begin
               m_bvld = 1'b1; m_bidx = widx; m_bdata = wd; m_bmask = wm;
            end else begin
               m_mem[widx] = merge(m_mem[widx], wd, wm);
            end
         end
         if (inv) modelFill();
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, '0, '0, '0);
   endtask

   task automatic readAll();
      for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 4'(i), 0, '0, '0, '0);
      idle(1);
   endtask

   initial begin
      rst = 1'b0; inv_req = 0; rd_vld = 0; rd_idx = '0;
      wr_vld = 0; wr_idx = '0; wr_data = '0; wr_mask = '0;
      m_rd_data = '0; m_rd_vld = 0; m_bvld = 0; m_bidx = '0; m_bdata = '0; m_bmask = '0;
      @(posedge clk); #1;
      doReset();
      idle(DEPTH + 2);
      readAll();

      // Partial write then read back
      applyStimulus(0, 0, '0, 1, 4'd3, 16'hFFFF, 16'h00F0);
      applyStimulus(0, 1, 4'd3, 0, '0, '0, '0);
      idle(1);
      checkOutput("partial_55F5", rd_data, 16'h55F5);

      // Read/write collision on idx 7, read while buffered, then after drain
      applyStimulus(0, 1, 4'd7, 1, 4'd7, 16'hAAAA, 16'hFFFF);
      applyStimulus(0, 1, 4'd7, 0, '0, '0, '0);
`ifdef AQ_BHT_WBUF_BYPASS_EN
      checkOutput("byp_read7", rd_data, 16'hAAAA);
`else
      checkOutput("stale_read7", rd_data, FILL);
`endif
      idle(1);
      applyStimulus(0, 1, 4'd7, 0, '0, '0, '0);
      idle(1);
      checkOutput("drained_read7", rd_data, 16'hAAAA);

      // Buffered write held behind 20 back-to-back reads
      applyStimulus(0, 1, 4'd1, 1, 4'd9, 16'h1234, 16'hFF00);
      for (int i = 0; i < 20; i++)
         applyStimulus(0, 1, 4'($urandom_range(0, DEPTH-1)), 1, 4'd2, 16'hBEEF, 16'hFFFF);
      idle(2);
      applyStimulus(0, 1, 4'd9, 0, '0, '0, '0);
      idle(1);
      checkOutput("held_write9", rd_data, 16'h1255);

      // Randomised traffic
      for (int i = 0; i < 300; i++)
         applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom),
                       1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
      idle(DEPTH + 1);

      // Invalidate with a buffered write pending
      applyStimulus(0, 1, 4'd0, 1, 4'd5, 16'h0F0F, 16'hFFFF);
      applyStimulus(1, 0, '0, 0, '0, '0, '0);
      idle(DEPTH + 1);
      readAll();

      // Reset at sweep count 5
      applyStimulus(1, 0, '0, 0, '0, '0, '0);
      idle(5);
      doReset();
      idle(DEPTH + 1);
      readAll();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
